// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for the skid pipe stage.
// Optional store-data lane: define PIPE_STAGE_STORE_DATA_EN.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int MADDR_W_DEF = 32;
  localparam int CMD_W_DEF   = 6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Encoding doubles as the held-entry count.
  function automatic logic [1:0] occ_of(state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload entry of the skid stage; clear wins over load.
// Width is set by the parent, so no feature macro is needed here.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        q_q <= '0;
      end else if (ld_i) begin
        q_q <= d_i;
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipe stage with registered upstream ready.
// Store-data lane is present only with PIPE_STAGE_STORE_DATA_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int MADDR_W = MADDR_W_DEF,
  parameter int CMD_W   = CMD_W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic               up_valid_in,
  output logic               up_ready_out,
  input  logic [RADDR_W-1:0] up_rd_addr_in,
  input  logic [DATA_W-1:0]  up_rd_data_in,
  input  logic               up_rd_we_in,
  input  logic [MADDR_W-1:0] up_mem_addr_in,
  input  logic [CMD_W-1:0]   up_cmd_in,
`ifdef PIPE_STAGE_STORE_DATA_EN
  input  logic [DATA_W-1:0]  up_store_data_in,
  output logic [DATA_W-1:0]  dn_store_data_out,
`endif
  output logic               dn_valid_out,
  input  logic               dn_ready_in,
  output logic [RADDR_W-1:0] dn_rd_addr_out,
  output logic [DATA_W-1:0]  dn_rd_data_out,
  output logic               dn_rd_we_out,
  output logic [MADDR_W-1:0] dn_mem_addr_out,
  output logic [CMD_W-1:0]   dn_cmd_out,
  output logic [1:0]         occ_out
);

`ifdef PIPE_STAGE_STORE_DATA_EN
  localparam int PW =
    RADDR_W + DATA_W + 1 + MADDR_W + CMD_W + DATA_W;
`else
  localparam int PW =
    RADDR_W + DATA_W + 1 + MADDR_W + CMD_W;
`endif

  state_e  state_q, state_d;
  logic    up_ready_q;
  logic    push, pop;
  logic    main_ld, skid_ld;
  logic [PW-1:0] up_pl, main_d, main_q, skid_q, dn_pl;

`ifdef PIPE_STAGE_STORE_DATA_EN
  assign up_pl = {up_store_data_in, up_cmd_in,
                  up_mem_addr_in, up_rd_we_in,
                  up_rd_data_in, up_rd_addr_in};
  assign {dn_store_data_out, dn_cmd_out,
          dn_mem_addr_out, dn_rd_we_out,
          dn_rd_data_out, dn_rd_addr_out} = dn_pl;
`else
  assign up_pl = {up_cmd_in, up_mem_addr_in,
                  up_rd_we_in, up_rd_data_in,
                  up_rd_addr_in};
  assign {dn_cmd_out, dn_mem_addr_out,
          dn_rd_we_out, dn_rd_data_out,
          dn_rd_addr_out} = dn_pl;
`endif

  assign dn_valid_out = (state_q != ST_EMPTY);
  assign dn_pl        = dn_valid_out ? main_q : '0;
  assign up_ready_out = up_ready_q;
  assign occ_out      = occ_of(state_q);

  assign push = up_valid_in & up_ready_q;
  assign pop  = dn_valid_out & dn_ready_in;

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = up_pl;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_ld = 1'b1;
        end else if (push) begin
          state_d = ST_TWO;
          skid_ld = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d = ST_ONE;
          main_ld = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_in) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_EMPTY;
      up_ready_q <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      up_ready_q <= (state_d != ST_TWO);
    end
  end

  pipe_entry_reg #(.W(PW)) u_main (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .en_i   (rdy_in),
    .clr_i  (flush_in),
    .ld_i   (main_ld),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_entry_reg #(.W(PW)) u_skid (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .en_i   (rdy_in),
    .clr_i  (flush_in),
    .ld_i   (skid_ld),
    .d_i    (up_pl),
    .q_o    (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + random bench for pipe_stage_skid against a queue model.
// Covers the store-data lane when PIPE_STAGE_STORE_DATA_EN is set.
module tb_pipe_stage_skid;

  typedef struct packed {
`ifdef PIPE_STAGE_STORE_DATA_EN
    logic [31:0] sd;
`endif
    logic [5:0]  cmd;
    logic [31:0] ma;
    logic        we;
    logic [31:0] rd;
    logic [4:0]  ra;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n, rdy, flush, up_valid, up_ready;
  logic  dn_valid, dn_ready;
  logic [1:0] occ;
  beat_t up_b, dn_b;

  logic [4:0]  dn_ra;
  logic [31:0] dn_rd, dn_ma;
  logic        dn_we;
  logic [5:0]  dn_cmd;
`ifdef PIPE_STAGE_STORE_DATA_EN
  logic [31:0] dn_sd;
  assign dn_b.sd = dn_sd;
`endif
  assign dn_b.cmd = dn_cmd;
  assign dn_b.ma  = dn_ma;
  assign dn_b.we  = dn_we;
  assign dn_b.rd  = dn_rd;
  assign dn_b.ra  = dn_ra;

  pipe_stage_skid dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .rdy_in          (rdy),
    .flush_in        (flush),
    .up_valid_in     (up_valid),
    .up_ready_out    (up_ready),
    .up_rd_addr_in   (up_b.ra),
    .up_rd_data_in   (up_b.rd),
    .up_rd_we_in     (up_b.we),
    .up_mem_addr_in  (up_b.ma),
    .up_cmd_in       (up_b.cmd),
`ifdef PIPE_STAGE_STORE_DATA_EN
    .up_store_data_in  (up_b.sd),
    .dn_store_data_out (dn_sd),
`endif
    .dn_valid_out    (dn_valid),
    .dn_ready_in     (dn_ready),
    .dn_rd_addr_out  (dn_ra),
    .dn_rd_data_out  (dn_rd),
    .dn_rd_we_out    (dn_we),
    .dn_mem_addr_out (dn_ma),
    .dn_cmd_out      (dn_cmd),
    .occ_out         (occ)
  );

  // Reference: FIFO of accepted beats plus the registered ready flag.
  beat_t q[$];
  bit    m_rdy;
  int    total = 0;
  int    bad   = 0;

  function automatic beat_t rand_beat();
    beat_t b;
    b = '0;
    b.ra  = 5'($urandom);
    b.rd  = $urandom;
    b.we  = 1'($urandom);
    b.ma  = $urandom;
    b.cmd = 6'($urandom);
`ifdef PIPE_STAGE_STORE_DATA_EN
    b.sd  = $urandom;
`endif
    return b;
  endfunction

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    beat_t e;
    e = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".valid"}, 128'(dn_valid), 128'(q.size() > 0));
    chk({tag, ".occ"}, 128'(occ), 128'(q.size()));
    chk({tag, ".uprdy"}, 128'(up_ready), 128'(m_rdy));
    chk({tag, ".data"}, 128'(dn_b), 128'(e));
  endtask

  // One clock edge: advance the model from the inputs seen at the edge.
  task automatic tick(string tag);
    bit do_push, do_pop;
    beat_t nb;
    do_push = up_valid && m_rdy;
    do_pop  = dn_ready && (q.size() > 0);
    nb      = up_b;
    @(posedge clk);
    if (rst_n && rdy) begin
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(nb);
      end
      m_rdy = (q.size() < 2);
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    up_valid = 0; flush = 0; rdy = 1; dn_ready = 0;
    up_b = '0;
  endtask

  beat_t a, b, snap_b;
  logic [1:0] snap_occ;
  int n_out;

  initial begin
    rst_n = 0;
    idle();
    q.delete();
    m_rdy = 0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    tick("rst_rel");
    chk("uprdy_after_rst", 128'(up_ready), 128'(1));

    // Single push, one-cycle latency
    a = '0; a.ra = 5'd5; a.rd = 32'h1234; a.we = 1'b1;
    up_b = a; up_valid = 1; dn_ready = 1;
    tick("push1");
    chk("push1_occ", 128'(occ), 128'(1));
    chk("push1_beat", 128'(dn_b), 128'(a));
    up_valid = 0;
    tick("drain1");

    // Fill to two entries, then drain in order
    dn_ready = 0;
    a = rand_beat(); b = rand_beat();
    up_b = a; up_valid = 1;
    tick("fillA");
    up_b = b;
    tick("fillB");
    chk("two_occ", 128'(occ), 128'(2));
    chk("two_uprdy", 128'(up_ready), 128'(0));
    up_valid = 0; dn_ready = 1;
    chk("popA", 128'(dn_b), 128'(a));
    tick("popA_t");
    chk("popB", 128'(dn_b), 128'(b));
    tick("popB_t");

    // Flush in TWO with a coincident push
    dn_ready = 0; up_valid = 1;
    up_b = rand_beat(); tick("f1");
    up_b = rand_beat(); tick("f2");
    flush = 1; up_b = rand_beat(); dn_ready = 1;
    tick("flush");
    chk("flush_occ", 128'(occ), 128'(0));
    chk("flush_valid", 128'(dn_valid), 128'(0));
    chk("flush_data", 128'(dn_b), 128'(0));
    flush = 0; up_valid = 0; dn_ready = 0;
    tick("post_flush");

    // Stall with rdy low: flush and valid are ignored
    up_valid = 1; up_b = rand_beat(); tick("s1");
    snap_occ = occ; snap_b = dn_b;
    rdy = 0; flush = 1; dn_ready = 1;
    up_b = rand_beat();
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_occ", 128'(occ), 128'(snap_occ));
      chk("stall_data", 128'(dn_b), 128'(snap_b));
    end
    rdy = 1; flush = 0; up_valid = 0;
    tick("unstall");
    tick("unstall2");

    // Streaming: one beat per cycle, order preserved
    dn_ready = 1; up_valid = 1;
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      up_b = rand_beat();
      tick("stream");
      if (dn_valid && dn_ready) n_out++;
    end
    up_valid = 0;
    chk("stream_uprdy", 128'(up_ready), 128'(1));
    chk("stream_rate", 128'(n_out), 128'(100));
    tick("stream_end");

    // Random mix of everything
    for (int i = 0; i < 300; i++) begin
      up_valid = 1'($urandom);
      dn_ready = 1'($urandom);
      rdy      = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      up_b     = rand_beat();
      tick("rand");
    end

    // Async reset in TWO
    idle();
    up_valid = 1;
    up_b = rand_beat(); tick("r1");
    up_b = rand_beat(); tick("r2");
    up_valid = 0;
    tick("r3");
    chk("pre_rst_occ", 128'(occ), 128'(2));
    @(negedge clk);
    #2;
    rst_n = 0;
    q.delete(); m_rdy = 0;
    #1;
    chk("arst_valid", 128'(dn_valid), 128'(0));
    chk("arst_occ", 128'(occ), 128'(0));
    check_all("arst");
    @(negedge clk);
    rst_n = 1;
    tick("arst_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
